// File: rtl/mem_stage_sram_ctrl.sv
// Multi-cycle MEM-stage controller for a single-port asynchronous SRAM; ready=0 freezes the pipeline.
// Optional macro MEM_CTRL_LAST_HIT_EN adds a one-entry last-access buffer that serves repeat reads.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned SRAM_AW       = 18,
    parameter int unsigned ACCESS_CYCLES = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [31:0]        sram_dq_in,
    output logic               sram_we_n
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] FIRST_CNT = 8'd1;
    localparam logic [7:0] LAST_CNT  = 8'(ACCESS_CYCLES - 2);

    state_t             state_q;
    logic [7:0]         cnt_q;
    logic               wr_op_q;
    logic [31:0]        rdata_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [31:0]        sram_dq_out_q;
    logic               sram_dq_oe_q;
    logic               sram_we_n_q;

    logic               req;
    logic               hit;
    logic [SRAM_AW-1:0] word_d;

    assign req    = rd_en | wr_en;
    assign word_d = SRAM_AW'((address - BASE_ADDR) >> 2);

    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;

    always_comb begin
        ready = 1'b0;
        case (state_q)
            IDLE:    ready = ~req | hit;
            ACCESS:  ready = 1'b0;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // The write strobe is released one cycle early so data stays valid past the rising edge of we_n.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_op_q       <= 1'b0;
            rdata_q       <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        rdata_q <= rdata;
                    end else if (req) begin
                        wr_op_q       <= wr_en;
                        sram_addr_q   <= word_d;
                        sram_dq_out_q <= wdata;
                        sram_dq_oe_q  <= wr_en;
                        sram_we_n_q   <= ~(wr_en && (FIRST_CNT != LAST_CNT));
                        cnt_q         <= FIRST_CNT;
                        state_q       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == LAST_CNT) begin
                        if (!wr_op_q) begin
                            rdata_q <= sram_dq_in;
                        end
                        sram_dq_oe_q <= 1'b0;
                        sram_we_n_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q       <= cnt_q + 8'd1;
                        sram_we_n_q <= ~(wr_op_q && ((cnt_q + 8'd1) != LAST_CNT));
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_CTRL_LAST_HIT_EN
    logic               hit_valid_q;
    logic [SRAM_AW-1:0] hit_tag_q;
    logic [31:0]        hit_data_q;

    // Captures whatever the last completed access moved across the SRAM bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_valid_q <= 1'b0;
            hit_tag_q   <= '0;
            hit_data_q  <= '0;
        end else if (state_q == ACCESS && cnt_q == LAST_CNT) begin
            hit_valid_q <= 1'b1;
            hit_tag_q   <= sram_addr_q;
            hit_data_q  <= wr_op_q ? sram_dq_out_q : sram_dq_in;
        end
    end

    assign hit   = (state_q == IDLE) && rd_en && !wr_en && hit_valid_q && (hit_tag_q == word_d);
    assign rdata = hit ? hit_data_q : rdata_q;
`else
    assign hit   = 1'b0;
    assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: directed scenarios plus randomized traffic against
// a cycle-index reference model and a behavioural SRAM.
module tb_mem_stage_sram_ctrl;
    localparam int          AC   = 6;
    localparam int unsigned BASE = 1024;
`ifdef MEM_CTRL_LAST_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [31:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_in;
    logic        sram_we_n;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(
        .BASE_ADDR    (BASE),
        .SRAM_AW      (18),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    int checks = 0;
    int passed = 0;

    logic [31:0] sramMem [0:262143];
    logic [31:0] refMem  [0:262143];

    function automatic logic [31:0] initWord(input logic [17:0] w);
        return {w[7:0], 6'h15, w};
    endfunction

    function automatic logic [17:0] mapWord(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[19:2];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) begin
            sramMem[i] = initWord(18'(i));
            refMem[i]  = initWord(18'(i));
        end
    end

    // Asynchronous SRAM: a word is stored whenever the strobe is held low across a clock edge.
    assign sram_dq_in = sramMem[sram_addr];
    always @(posedge clk) begin
        if (sram_dq_oe && !sram_we_n) begin
            sramMem[sram_addr] = sram_dq_out;
        end
    end

    // Reference model: k is the cycle index inside an access (0 = idle / request cycle).
    int          k = 0;
    bit          modelLive = 1'b0;
    bit          mWr = 1'b0;
    logic [17:0] eAddr = '0;
    logic [31:0] eDq = '0;
    logic [31:0] eRdata = '0;
    bit          hValid = 1'b0;
    logic [17:0] hTag = '0;
    logic [31:0] hData = '0;

    always @(negedge clk) begin : compareModel
        logic [17:0] w;
        bit          rq;
        bit          hitNow;
        logic        expReady;
        logic        expWe;
        logic        expOe;
        logic [31:0] expRd;
        w      = mapWord(address);
        rq     = rd_en | wr_en;
        hitNow = HIT_EN && (k == 0) && rd_en && !wr_en && hValid && (hTag == w);
        if (modelLive) begin
            if (k == 0) begin
                expReady = !rq || hitNow;
                expWe    = 1'b1;
                expOe    = 1'b0;
                expRd    = hitNow ? hData : eRdata;
            end else begin
                expReady = (k == AC - 1);
                expWe    = !(mWr && k <= AC - 3);
                expOe    = mWr && (k <= AC - 2);
                expRd    = eRdata;
            end
            checkOutput("ready", 32'(ready), 32'(expReady));
            checkOutput("sram_we_n", 32'(sram_we_n), 32'(expWe));
            checkOutput("sram_dq_oe", 32'(sram_dq_oe), 32'(expOe));
            checkOutput("sram_addr", 32'(sram_addr), 32'(eAddr));
            checkOutput("sram_dq_out", sram_dq_out, eDq);
            checkOutput("rdata", rdata, expRd);
        end
        if (!rst) begin
            k         = 0;
            eAddr     = '0;
            eDq       = '0;
            eRdata    = '0;
            hValid    = 1'b0;
            modelLive = 1'b1;
        end else if (modelLive) begin
            if (k == 0) begin
                if (hitNow) begin
                    eRdata = hData;
                end else if (rq) begin
                    k     = 1;
                    mWr   = wr_en;
                    eAddr = w;
                    eDq   = wdata;
                    if (wr_en) refMem[w] = wdata;
                end
            end else if (k == AC - 2) begin
                k = AC - 1;
                if (!mWr) eRdata = refMem[eAddr];
                hValid = 1'b1;
                hTag   = eAddr;
                hData  = mWr ? eDq : eRdata;
            end else if (k == AC - 1) begin
                k = 0;
            end else begin
                k = k + 1;
            end
        end
    end

    // Holds the request until the completion cycle; returns freeze length and observed strobe pattern.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input bit jitter, output int lowCycles, output logic [7:0] wePat,
                                 output logic [17:0] addrSeen, output logic [31:0] dqSeen);
        @(posedge clk);
        #1;
        rd_en     = rd;
        wr_en     = wr;
        address   = a;
        wdata     = d;
        lowCycles = 0;
        wePat     = '0;
        addrSeen  = '0;
        dqSeen    = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 8) wePat[c] = sram_we_n;
            if (c == 1) begin
                addrSeen = sram_addr;
                dqSeen   = sram_dq_out;
            end
            if (ready) break;
            lowCycles++;
            if (jitter) begin
                @(posedge clk);
                #1;
                address = $urandom;
                wdata   = $urandom;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        address = $urandom;
        wdata   = $urandom;
        if (n > 1) repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        int          lc;
        int          lc2;
        logic [7:0]  wp;
        logic [17:0] as;
        logic [31:0] ds;
        logic        rd;
        logic        wr;
        logic [31:0] a;

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("reset_rdata", rdata, 32'd0);

        // Reset asserted for two cycles starting in the second ACCESS cycle of a write.
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        address = 32'd1060;
        wdata   = 32'h12345678;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        checkOutput("midwrite_strobe", 32'(sram_we_n), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("rst_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("rst_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_dq_out", sram_dq_out, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(ready), 32'd1);

        applyStimulus(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, lc, wp, as, ds);
        checkOutput("wr_freeze", 32'(lc), 32'd5);
        checkOutput("wr_we_pattern", 32'(wp), 32'h31);
        checkOutput("wr_addr", 32'(as), 32'd2);
        checkOutput("wr_dq", ds, 32'hDEADBEEF);

        applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, lc, wp, as, ds);
        checkOutput("rd_freeze", 32'(lc), 32'd5);
        checkOutput("rd_we_pattern", 32'(wp), 32'h3F);
        checkOutput("rd_data", rdata, 32'hDEADBEEF);
        idleCycles(1);

        applyStimulus(1'b0, 1'b1, 32'd1024, 32'h11112222, 1'b0, lc, wp, as, ds);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, lc2, wp, as, ds);
        checkOutput("b2b_freeze1", 32'(lc), 32'd5);
        checkOutput("b2b_freeze2", 32'(lc2), 32'd5);
        checkOutput("b2b_rdata", rdata, initWord(18'd1));
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, lc, wp, as, ds);
        checkOutput("b2b_readback", rdata, 32'h11112222);

        applyStimulus(1'b1, 1'b1, 32'd1049600, 32'hCAFEF00D, 1'b0, lc, wp, as, ds);
        checkOutput("conflict_addr", 32'(as), 32'd0);
        checkOutput("conflict_freeze", 32'(lc), 32'd5);
        checkOutput("conflict_rdata", rdata, 32'h11112222);
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, lc, wp, as, ds);
        checkOutput("wrap_readback", rdata, 32'hCAFEF00D);
        idleCycles(1);

        applyStimulus(1'b0, 1'b1, 32'd1040, 32'h0BADC0DE, 1'b0, lc, wp, as, ds);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, lc, wp, as, ds);
        checkOutput("lasthit_freeze", 32'(lc), HIT_EN ? 32'd0 : 32'd5);
        checkOutput("lasthit_rdata", rdata, 32'h0BADC0DE);
        applyStimulus(1'b1, 1'b0, 32'd1044, 32'h0, 1'b0, lc, wp, as, ds);
        checkOutput("miss_freeze", 32'(lc), 32'd5);
        idleCycles(1);

        for (int t = 0; t < 150; t++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + 4 * $urandom_range(0, 15);
            applyStimulus(rd, wr, a, $urandom, 1'b1, lc, wp, as, ds);
            checkOutput("rand_bounded", 32'(lc < 20), 32'd1);
            if ($urandom_range(0, 2) != 0) idleCycles($urandom_range(1, 2));
        end

        idleCycles(3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion by %0t, expected end of stimulus", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
